// File: rtl/adc_paddle_filter.sv
// Paddle position conditioner for a dual-slope ADC: edge-detects conversions,
// keeps a 2^AVG_LOG2 moving average, clamps, applies hysteresis and flags stalls.
module adc_paddle_filter #(
  parameter int AVG_LOG2 = 2,
  parameter int HYST     = 2,
  parameter int POS_MIN  = 16,
  parameter int POS_MAX  = 239,
  parameter int TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       select_v_ref,
  input  logic [7:0] digit_val,
  output logic [7:0] paddle_pos,
  output logic       pos_valid,
  output logic       primed,
  output logic       stale
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = 8 + AVG_LOG2;
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CW = AVG_LOG2 + 1;

  localparam logic [7:0]    MIN8     = 8'(POS_MIN);
  localparam logic [7:0]    MAX8     = 8'(POS_MAX);
  localparam logic [7:0]    MID8     = 8'((POS_MIN + POS_MAX) / 2);
  localparam logic [8:0]    HYST9    = 9'(HYST);
  localparam logic [15:0]   TMO16    = 16'(TIMEOUT);
  localparam logic [PW-1:0] LAST_PTR = PW'(N - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic              sel_d_r;
  logic              done_s;
  logic [7:0]        sample_r;
  logic              s1_vld_r;
  logic [7:0]        ring_r [N];
  logic [SW-1:0]     sum_r, sum_nxt_s;
  logic [7:0]        old_s;
  logic [PW-1:0]     wr_ptr_r;
  logic [CW-1:0]     fill_cnt_r;
  logic              last_fill_s;
  logic              cand_vld_r;
  logic              have_pos_r;
  logic [7:0]        avg_s, cand_s;
  logic signed [8:0] diff_s;
  logic [8:0]        mag_s;
  logic              rail_s, upd_s;
  logic [15:0]       tmo_cnt_r, tmo_nxt_s;
  logic [7:0]        paddle_pos_r;
  logic              pos_valid_r, primed_r, stale_r;

  assign done_s = sel_d_r & ~select_v_ref;

  // Averaging datapath: entry being overwritten counts as zero until the ring is full.
  always_comb begin
    old_s       = (state_r == FILL) ? 8'd0 : ring_r[wr_ptr_r];
    sum_nxt_s   = sum_r - SW'(old_s) + SW'(sample_r);
    last_fill_s = (state_r == FILL) && (fill_cnt_r == LAST_CNT);
  end

  // Fill/run next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILL: begin
        if (s1_vld_r && (fill_cnt_r == LAST_CNT)) state_nxt_s = RUN;
        else                                      state_nxt_s = FILL;
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = FILL;
    endcase
  end

  // Candidate: floor average, clamped before the hysteresis compare.
  always_comb begin
    avg_s = 8'(sum_r >> AVG_LOG2);
    if (avg_s < MIN8)      cand_s = MIN8;
    else if (avg_s > MAX8) cand_s = MAX8;
    else                   cand_s = avg_s;
    diff_s = $signed({1'b0, cand_s}) - $signed({1'b0, paddle_pos_r});
    mag_s  = diff_s[8] ? 9'(-diff_s) : 9'(diff_s);
    rail_s = ((cand_s == MIN8) || (cand_s == MAX8)) && (cand_s != paddle_pos_r);
    upd_s  = cand_vld_r && (!have_pos_r || (mag_s > HYST9) || rail_s);
  end

  // Saturating stall counter; stale mirrors counter == TIMEOUT.
  always_comb begin
    if (done_s)                  tmo_nxt_s = 16'd0;
    else if (tmo_cnt_r == TMO16) tmo_nxt_s = tmo_cnt_r;
    else                         tmo_nxt_s = tmo_cnt_r + 16'd1;
  end

  // Conversion-complete edge detect and S1 sample capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_d_r  <= 1'b0;
      s1_vld_r <= 1'b0;
      sample_r <= 8'd0;
    end else begin
      sel_d_r  <= select_v_ref;
      s1_vld_r <= done_s;
      if (done_s) sample_r <= digit_val;
    end
  end

  // S2: ring buffer, running sum, pointer, fill count and primed flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) ring_r[i] <= 8'd0;
      sum_r      <= '0;
      wr_ptr_r   <= '0;
      fill_cnt_r <= '0;
      primed_r   <= 1'b0;
      cand_vld_r <= 1'b0;
    end else begin
      cand_vld_r <= s1_vld_r && ((state_r == RUN) || last_fill_s);
      if (s1_vld_r) begin
        ring_r[wr_ptr_r] <= sample_r;
        sum_r            <= sum_nxt_s;
        wr_ptr_r         <= (wr_ptr_r == LAST_PTR) ? PW'(0) : wr_ptr_r + PW'(1);
        if (state_r == FILL) fill_cnt_r <= fill_cnt_r + CW'(1);
        if (last_fill_s)     primed_r   <= 1'b1;
      end
    end
  end

  // Fill/run state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= FILL;
    else          state_r <= state_nxt_s;
  end

  // S3: publish position; the first candidate after priming is taken unconditionally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      paddle_pos_r <= MID8;
      pos_valid_r  <= 1'b0;
      have_pos_r   <= 1'b0;
    end else begin
      pos_valid_r <= upd_s;
      if (upd_s) begin
        paddle_pos_r <= cand_s;
        have_pos_r   <= 1'b1;
      end
    end
  end

  // Stall timer and stale flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_r <= 16'd0;
      stale_r   <= 1'b0;
    end else begin
      tmo_cnt_r <= tmo_nxt_s;
      stale_r   <= (tmo_nxt_s == TMO16);
    end
  end

  assign paddle_pos = paddle_pos_r;
  assign pos_valid  = pos_valid_r;
  assign primed     = primed_r;
  assign stale      = stale_r;

endmodule

// File: tb/tb_adc_paddle_filter.sv
// Scoreboard bench for adc_paddle_filter: a windowed-average reference model
// predicts every pos_valid pulse; a forked monitor checks value and timing.
module tb_adc_paddle_filter;

  localparam int N = 4;
  localparam int HYST = 2;
  localparam int PMIN = 16;
  localparam int PMAX = 239;
  localparam int TMO = 1024;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       select_v_ref = 1'b1;
  logic [7:0] digit_val = 8'd0;
  logic [7:0] paddle_pos;
  logic       pos_valid, primed, stale;

  adc_paddle_filter dut (
    .clk(clk), .reset_n(reset_n), .select_v_ref(select_v_ref), .digit_val(digit_val),
    .paddle_pos(paddle_pos), .pos_valid(pos_valid), .primed(primed), .stale(stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] pos;
    int         at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  int   nconv;
  bit   have;
  int   mpos;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    nconv = 0;
    have  = 1'b0;
    mpos  = (PMIN + PMAX) / 2;
  endtask

  // Reference: average of the last N conversions, clamp, then deadband/rail rule.
  task automatic model_conv(input int v, input int e0);
    int s, cand, d;
    exp_t e;
    hist.push_back(v);
    if (hist.size() > N) void'(hist.pop_front());
    nconv++;
    if (nconv >= N) begin
      s = 0;
      foreach (hist[i]) s += hist[i];
      cand = s / N;
      if (cand < PMIN) cand = PMIN;
      if (cand > PMAX) cand = PMAX;
      d = (cand > mpos) ? cand - mpos : mpos - cand;
      if (!have || d > HYST || ((cand == PMIN || cand == PMAX) && cand != mpos)) begin
        mpos     = cand;
        have     = 1'b1;
        e.pos    = 8'(cand);
        e.at_cyc = e0 + 2;
        exp_q.push_back(e);
      end
    end
  endtask

  // Returns at the negedge just after the detection edge E0.
  task automatic conv(input logic [7:0] v);
    @(negedge clk);
    select_v_ref = 1'b0;
    digit_val    = v;
    model_conv(int'(v), cyc + 1);
    @(negedge clk);
    select_v_ref = 1'b1;
    digit_val    = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (pos_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pulse: unexpected pos_valid with paddle_pos %0d at cycle %0d", paddle_pos, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_pos", 16'(paddle_pos), 16'(e.pos));
          chk("pulse_cyc", 16'(cyc), 16'(e.at_cyc));
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].at_cyc) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_pulse: no pos_valid pulse for expected pos %0d at cycle %0d", e.pos, e.at_cyc);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    model_reset();
    fork
      monitor();
    join_none

    // Reset held with select toggling
    repeat (6) begin
      @(negedge clk);
      select_v_ref = ~select_v_ref;
    end
    chk("rst_pos", 16'(paddle_pos), 16'd127);
    chk("rst_valid", 16'(pos_valid), 16'd0);
    chk("rst_primed", 16'(primed), 16'd0);
    chk("rst_stale", 16'(stale), 16'd0);
    @(negedge clk);
    select_v_ref = 1'b0;
    digit_val    = 8'd0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    select_v_ref = 1'b1;
    idle(3);

    // Fill with 100
    repeat (3) begin
      conv(8'd100);
      idle(3);
    end
    chk("primed_pre", 16'(primed), 16'd0);
    conv(8'd100);
    chk("primed_e0", 16'(primed), 16'd0);
    @(negedge clk);
    chk("primed_e1", 16'(primed), 16'd1);
    idle(4);
    chk("fill_pos", 16'(paddle_pos), 16'd100);

    // Hysteresis
    repeat (4) begin
      conv(8'd102);
      idle(3);
    end
    chk("hyst_hold", 16'(paddle_pos), 16'd100);
    conv(8'd104);
    idle(3);
    conv(8'd104);
    idle(4);
    chk("hyst_move", 16'(paddle_pos), 16'd103);

    // Clamp and rails
    repeat (4) begin
      conv(8'd5);
      idle(2);
    end
    idle(3);
    chk("clamp_lo", 16'(paddle_pos), 16'd16);
    repeat (4) begin
      conv(8'd250);
      idle(2);
    end
    idle(3);
    chk("clamp_hi", 16'(paddle_pos), 16'd239);
    repeat (4) begin
      conv(8'd237);
      idle(2);
    end
    idle(3);
    chk("rail_hold", 16'(paddle_pos), 16'd239);

    // Timeout: E0 is the edge just before conv returns
    conv(8'd237);
    idle(TMO - 1);
    chk("stale_early", 16'(stale), 16'd0);
    idle(1);
    chk("stale_set", 16'(stale), 16'd1);
    idle(50);
    chk("stale_sat", 16'(stale), 16'd1);
    chk("stale_pos", 16'(paddle_pos), 16'(mpos));
    conv(8'd237);
    chk("stale_clr", 16'(stale), 16'd0);
    idle(4);

    // Reset mid-fill
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    chk("mrst_primed", 16'(primed), 16'd0);
    chk("mrst_pos", 16'(paddle_pos), 16'd127);
    conv(8'd200);
    idle(2);
    conv(8'd200);
    idle(2);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    chk("mfill_primed", 16'(primed), 16'd0);
    chk("mfill_pos", 16'(paddle_pos), 16'd127);
    repeat (4) begin
      conv(8'd60);
      idle(2);
    end
    idle(3);
    chk("mfill_new", 16'(paddle_pos), 16'd60);

    // Randomized traffic, including back-to-back conversions
    last = 60;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) last = int'($urandom_range(0, 255));
      else begin
        last = last + int'($urandom_range(0, 8)) - 4;
        if (last < 0) last = 0;
        if (last > 255) last = 255;
      end
      conv(8'(last));
      idle(int'($urandom_range(0, 3)));
    end
    idle(6);
    chk("final_pos", 16'(paddle_pos), 16'(mpos));
    chk("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
